des_key_schedule_seq: RTL and testbench
=======================================

Name: des_key_schedule_seq

Overview:
- Sequential, parametrised DES/3DES key scheduler. Accepts one 64-bit key per stage and streams one 48-bit round subkey per cycle under valid/ready backpressure.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1) per stage.
- Replaces the all-16-outputs-at-once combinational generator in front of an iterative round datapath.
- With NUM_KEYS=3 it streams 48 subkeys in EDE order for 3DES.

Parameters:
- NUM_KEYS, 1, key stages per job: 1 = single DES, 3 = 3DES EDE; other values are illegal (elaboration error).
- ROUNDS, 16, rounds per stage; fixed by the DES shift table.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset; asynchronous assert, active-low
- key_valid  input  1  key job offered
- key_ready  output  1  high only in IDLE
- key  input  64*NUM_KEYS  stage keys; K1 in the MSB 64 bits, bit 1 = MSB; parity bits included
- decrypt  input  1  direction; sampled on key accept
- sk_valid  output  1  subkey beat valid
- sk_ready  input  1  consumer accepts beat
- subkey  output  48  PC2(C,D) of the current round
- sk_round  output  4  round index 0..15 within the current stage
- sk_stage  output  2  stage index 0..NUM_KEYS-1
- sk_last  output  1  final beat of the job
- busy  output  1  high whenever not IDLE
- key_err  output  1  one-cycle parity error pulse; see Optional Feature

Behaviour:
- Reset (async, rst_n=0) forces, immediately:
  - state=IDLE, C=D=0, round=0, stage=0
  - sk_valid=0, sk_last=0, busy=0, key_err=0, key_ready=1 after release
  - A job in flight is abandoned silently.
- FSM has two states: IDLE and EMIT.
- IDLE:
  - Accept occurs when key_valid && key_ready.
  - On the accept edge: latch key and decrypt, set stage=0, round=0, load C/D with the stage-0 initial value, go to EMIT.
  - sk_valid rises the cycle after accept (latency 1).
- Initial C/D value for a stage:
  - Forward stage: {C,D} = PC1(key) each rotated left by SHIFT[1]=1.
  - Reverse stage: {C,D} = PC1(key) unrotated, since C16D16 = C0D0.
- Stage direction:
  - decrypt=0: stages 0,1,2 use K1-fwd, K2-rev, K3-fwd.
  - decrypt=1: stages use K3-rev, K2-fwd, K1-rev.
  - NUM_KEYS=1: single stage, forward if decrypt=0, reverse if decrypt=1.
- EMIT:
  - sk_valid=1 and subkey=PC2(C,D).
  - subkey, sk_round, sk_stage and sk_last hold stable while sk_ready=0.
- On each EMIT handshake with round<15:
  - round+1.
  - Forward: rotate C and D left by SHIFT[round+2].
  - Reverse: rotate right by RSHIFT[round+2], where RSHIFT = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- On the handshake with round=15:
  - If stage<NUM_KEYS-1: stage+1, round=0, load the next stage's initial C/D on the same edge. No bubble; sustained 1 beat/cycle.
  - Otherwise go to IDLE; sk_valid drops next cycle.
- sk_last = (stage==NUM_KEYS-1) && (round==15) && EMIT.
- key_valid during EMIT is ignored; key_ready=0 there.
- Rotations are 28-bit circular, independently on C and D.

Optional Feature:
- Macro: DES_KS_PARITY_CHECK_EN.
- Defined:
  - On accept, every key byte is checked for odd parity.
  - Any even-parity byte means the job is rejected: state stays IDLE, no sk_valid, key_err=1 for exactly the next cycle.
  - key_ready stays 1 throughout.
- Undefined:
  - Parity bits are ignored; key_err is tied to 0.
  - The port always exists.

Decomposition:
- Package des_ks_pkg holds:
  - PC1 table (56 entries) and PC2 table (48 entries)
  - SHIFT and RSHIFT schedules (16 entries each)
  - State enum {IDLE, EMIT}
  - Widths: KEY_W=64, CD_W=28, SK_W=48
- Sub-module des_pc2: pure combinational 56->48 permutation, instantiated once on the {C,D} register.

Test Plan:
1. NUM_KEYS=1, key=133457799BBCDFF1, decrypt=0, sk_ready=1 -> sk_valid one cycle after accept; beat0=1B02EFFC7072, beat1=79AED9DBC9E5, beat15=CB3D8B0E17F5 with sk_last=1; 16 consecutive beats.
2. Same key, decrypt=1 -> beat0=CB3D8B0E17F5, beat15=1B02EFFC7072; sk_round counts 0..15.
3. Backpressure: drop sk_ready for 5 cycles at sk_round=3 -> subkey, sk_round and sk_valid held constant; the sequence matches test 1 exactly afterwards.
4. NUM_KEYS=3, all three keys=133457799BBCDFF1, decrypt=0 -> 48 gapless beats:
   - stage0 beat0=1B02EFFC7072
   - stage1 beat0=CB3D8B0E17F5
   - stage2 beat0=1B02EFFC7072
   - sk_last only on beat 47
5. DES_KS_PARITY_CHECK_EN defined, key=133457799BBCDFF0 -> key_err high for 1 cycle, sk_valid never rises, key_ready stays 1. Valid key 133457799BBCDFF1 -> no key_err.
6. Assert rst_n=0 mid-stream at sk_round=7 -> sk_valid and busy drop asynchronously. After release, a new job restarts at round 0 with correct values.

Source files
------------

// File: rtl/des_ks_pkg.sv
// Shared tables, types and helpers for the sequential DES/3DES key scheduler.
// Bit numbering follows DES: bit 1 is the MSB of each table's source word.
package des_ks_pkg;

  localparam int KEY_W = 64;
  localparam int CD_W  = 28;
  localparam int SK_W  = 48;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Entry i is the left shift that produces round i+1.
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Entry i is the right shift that steps back to round 16-i.
  localparam logic [1:0] RSHIFT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [2*CD_W-1:0] pc1(
    input logic [KEY_W-1:0] k
  );
    logic [2*CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < 2*CD_W; i++)
      r[2*CD_W-1-i] = k[KEY_W-PC1[i]];
    return r;
  endfunction

  function automatic logic [CD_W-1:0] rotl28(
    input logic [CD_W-1:0] x,
    input logic [1:0]      n
  );
    logic [CD_W-1:0] r;
    case (n)
      2'd1:    r = {x[CD_W-2:0], x[CD_W-1]};
      2'd2:    r = {x[CD_W-3:0], x[CD_W-1:CD_W-2]};
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [CD_W-1:0] rotr28(
    input logic [CD_W-1:0] x,
    input logic [1:0]      n
  );
    logic [CD_W-1:0] r;
    case (n)
      2'd1:    r = {x[0], x[CD_W-1:1]};
      2'd2:    r = {x[1:0], x[CD_W-1:2]};
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_key_schedule_seq_pc2.sv
// DES permuted choice 2: selects 48 subkey bits from the 56-bit C||D word.
// Pure combinational wiring.
module des_pc2
  import des_ks_pkg::*;
(
  input  logic [2*CD_W-1:0] cd,
  output logic [SK_W-1:0]   sk
);

  // Table-driven bit gather
  always_comb begin
    sk = '0;
    for (int i = 0; i < SK_W; i++)
      sk[SK_W-1-i] = cd[2*CD_W-PC2[i]];
  end

endmodule

// File: rtl/des_key_schedule_seq.sv
// Sequential DES/3DES key scheduler: one 48-bit subkey per beat, EDE order.
// Optional odd-parity key check enabled by DES_KS_PARITY_CHECK_EN.
module des_key_schedule_seq
  import des_ks_pkg::*;
#(
  parameter int NUM_KEYS = 1,
  parameter int ROUNDS   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      key_valid,
  output logic                      key_ready,
  input  logic [KEY_W*NUM_KEYS-1:0] key,
  input  logic                      decrypt,
  output logic                      sk_valid,
  input  logic                      sk_ready,
  output logic [SK_W-1:0]           subkey,
  output logic [3:0]                sk_round,
  output logic [1:0]                sk_stage,
  output logic                      sk_last,
  output logic                      busy,
  output logic                      key_err
);

  localparam int         KW       = KEY_W * NUM_KEYS;
  localparam logic [1:0] LAST_STG = 2'(NUM_KEYS - 1);
  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

  if (!(NUM_KEYS == 1 || NUM_KEYS == 3)) begin : g_bad_nk
    $error("des_key_schedule_seq: NUM_KEYS must be 1 or 3");
  end
  if (ROUNDS != 16) begin : g_bad_rounds
    $error("des_key_schedule_seq: ROUNDS must be 16");
  end

  state_t            state_q, state_d;
  logic [KW-1:0]     key_q, key_d;
  logic              dec_q, dec_d;
  logic [3:0]        round_q, round_d;
  logic [1:0]        stage_q, stage_d;
  logic [2*CD_W-1:0] cd_q, cd_d;
  logic              rev_now;
  logic [3:0]        rnext;

  // Stage s uses key s (encrypt) or key N-1-s (decrypt); odd stages flip.
  function automatic logic [2*CD_W-1:0] stage_init(
    input logic [KW-1:0] keys,
    input logic          dec,
    input logic [1:0]    stg
  );
    int                idx;
    logic              rev;
    logic [KEY_W-1:0]  kk;
    logic [2*CD_W-1:0] cd;
    idx = dec ? (NUM_KEYS - 1 - int'(stg)) : int'(stg);
    rev = dec ^ stg[0];
    kk  = keys[KEY_W*(NUM_KEYS-1-idx) +: KEY_W];
    cd  = pc1(kk);
    if (!rev)
      cd = {rotl28(cd[2*CD_W-1:CD_W], 2'd1),
            rotl28(cd[CD_W-1:0], 2'd1)};
    return cd;
  endfunction

`ifdef DES_KS_PARITY_CHECK_EN
  logic key_err_q, key_err_d;

  function automatic logic par_ok(input logic [KW-1:0] k);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < KW/8; i++)
      if (!(^k[8*i +: 8])) ok = 1'b0;
    return ok;
  endfunction
`endif

  assign rev_now = dec_q ^ stage_q[0];
  assign rnext   = round_q + 4'd1;

  // Next-state: job accept, per-beat rotation, stage rollover
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    dec_d   = dec_q;
    round_d = round_q;
    stage_d = stage_q;
    cd_d    = cd_q;
`ifdef DES_KS_PARITY_CHECK_EN
    key_err_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
`ifdef DES_KS_PARITY_CHECK_EN
          if (!par_ok(key)) begin
            key_err_d = 1'b1;
          end else begin
`else
          begin
`endif
            key_d   = key;
            dec_d   = decrypt;
            stage_d = 2'd0;
            round_d = 4'd0;
            cd_d    = stage_init(key, decrypt, 2'd0);
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (sk_ready) begin
          if (round_q != LAST_RND) begin
            round_d = rnext;
            if (rev_now)
              cd_d = {rotr28(cd_q[2*CD_W-1:CD_W], RSHIFT[rnext]),
                      rotr28(cd_q[CD_W-1:0], RSHIFT[rnext])};
            else
              cd_d = {rotl28(cd_q[2*CD_W-1:CD_W], SHIFT[rnext]),
                      rotl28(cd_q[CD_W-1:0], SHIFT[rnext])};
          end else if (stage_q != LAST_STG) begin
            stage_d = stage_q + 2'd1;
            round_d = 4'd0;
            cd_d    = stage_init(key_q, dec_q, stage_q + 2'd1);
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      dec_q   <= 1'b0;
      round_q <= 4'd0;
      stage_q <= 2'd0;
      cd_q    <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      dec_q   <= dec_d;
      round_q <= round_d;
      stage_q <= stage_d;
      cd_q    <= cd_d;
    end
  end

`ifdef DES_KS_PARITY_CHECK_EN
  // One-cycle parity reject pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_err_q <= 1'b0;
    else        key_err_q <= key_err_d;
  end
  assign key_err = key_err_q;
`else
  assign key_err = 1'b0;
`endif

  des_pc2 u_pc2 (
    .cd (cd_q),
    .sk (subkey)
  );

  assign key_ready = (state_q == IDLE);
  assign busy      = (state_q == EMIT);
  assign sk_valid  = (state_q == EMIT);
  assign sk_round  = round_q;
  assign sk_stage  = stage_q;
  assign sk_last   = (state_q == EMIT) && (stage_q == LAST_STG)
                  && (round_q == LAST_RND);

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Bench for des_key_schedule_seq: single-DES and 3DES instances against a
// reference key schedule built from cumulative shifts.
module tb_des_key_schedule_seq;

  localparam logic [63:0] KAT  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KBAD = 64'h133457799BBCDFF0;

  localparam int TB_PC1 [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
    14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int TB_PC2 [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10,
    23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48,
    44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int TB_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  typedef struct {
    logic [47:0] sk;
    int          r;
    int          s;
    bit          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sel3, key_valid, decrypt, sk_ready;
  logic [191:0] key_in;

  logic kr1, skv1, last1, busy1, err1;
  logic [47:0] sk1;
  logic [3:0] rnd1;
  logic [1:0] stg1;
  logic kr3, skv3, last3, busy3, err3;
  logic [47:0] sk3;
  logic [3:0] rnd3;
  logic [1:0] stg3;

  logic o_kr, o_v, o_last, o_busy, o_err;
  logic [47:0] o_sk;
  logic [3:0] o_rnd;
  logic [1:0] o_stg;

  int checks = 0;
  int errors = 0;
  logic [47:0] log_sk[$];
  bit log_last[$];

  always #5 clk = ~clk;

  des_key_schedule_seq #(.NUM_KEYS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid & ~sel3), .key_ready(kr1),
    .key(key_in[191:128]), .decrypt(decrypt),
    .sk_valid(skv1), .sk_ready(sk_ready), .subkey(sk1),
    .sk_round(rnd1), .sk_stage(stg1), .sk_last(last1),
    .busy(busy1), .key_err(err1));

  des_key_schedule_seq #(.NUM_KEYS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid & sel3), .key_ready(kr3),
    .key(key_in), .decrypt(decrypt),
    .sk_valid(skv3), .sk_ready(sk_ready), .subkey(sk3),
    .sk_round(rnd3), .sk_stage(stg3), .sk_last(last3),
    .busy(busy3), .key_err(err3));

  always_comb begin
    o_kr   = sel3 ? kr3   : kr1;
    o_v    = sel3 ? skv3  : skv1;
    o_sk   = sel3 ? sk3   : sk1;
    o_rnd  = sel3 ? rnd3  : rnd1;
    o_stg  = sel3 ? stg3  : stg1;
    o_last = sel3 ? last3 : last1;
    o_busy = sel3 ? busy3 : busy1;
    o_err  = sel3 ? err3  : err1;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] rol(input logic [27:0] x, input int n);
    for (int i = 0; i < n; i++) x = {x[26:0], x[27]};
    return x;
  endfunction

  // Subkey for DES round rnd (1..16) straight from the definition
  function automatic logic [47:0] ref_sk(input logic [63:0] k,
                                         input int rnd);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] sk;
    int tot;
    tot = 0;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-TB_PC1[i]];
    for (int i = 0; i < rnd; i++) tot += TB_SH[i];
    c  = rol(cd[55:28], tot);
    d  = rol(cd[27:0], tot);
    cd = {c, d};
    for (int i = 0; i < 48; i++) sk[47-i] = cd[56-TB_PC2[i]];
    return sk;
  endfunction

  function automatic logic [63:0] fix_par(input logic [63:0] k);
    for (int b = 0; b < 8; b++) k[8*b] = ~^k[8*b+1 +: 7];
    return k;
  endfunction

  // mode 0: random ready at pct%; 1: 5-cycle stall at round 3;
  // 2: async reset at round 7
  task automatic run_job(input bit s3, input logic [191:0] k,
                         input bit dec, input int pct, input int mode);
    beat_t q[$];
    beat_t b;
    int n, idx, stall, cyc;
    bit rev, ready, done;
    logic [63:0] kk;
    n = s3 ? 3 : 1;
    stall = 0;
    cyc = 0;
    done = 0;
    log_sk.delete();
    log_last.delete();
    for (int s = 0; s < n; s++) begin
      idx = dec ? n - 1 - s : s;
      rev = dec ^ s[0];
      kk  = k[191 - 64*idx -: 64];
      for (int r = 0; r < 16; r++) begin
        b.sk   = ref_sk(kk, rev ? 16 - r : r + 1);
        b.r    = r;
        b.s    = s;
        b.last = (s == n - 1) && (r == 15);
        q.push_back(b);
      end
    end
    sel3 = s3;
    @(negedge clk);
    key_in = k;
    decrypt = dec;
    key_valid = 1'b1;
    sk_ready = 1'b0;
    chk("key_ready_idle", o_kr, 1);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    decrypt = ~dec;
    key_in = {6{$urandom}};
    chk("valid_lat1", o_v, 1);
    chk("busy_emit", o_busy, 1);
    chk("key_ready_emit", o_kr, 0);
    chk("key_err_ok", o_err, 0);
    while (q.size() > 0 && !done) begin
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin
        chk("timeout", 0, 1);
        done = 1;
      end else begin
        if (mode == 1) begin
          ready = !(q[0].r == 3 && stall < 5);
          if (!ready) stall++;
        end else begin
          ready = ($urandom_range(99) < pct);
        end
        sk_ready = ready;
        chk("valid_gapless", o_v, 1);
        if (mode == 2 && q[0].r == 7) begin
          #2 rst_n = 1'b0;
          #1;
          chk("rst_valid", o_v, 0);
          chk("rst_busy", o_busy, 0);
          chk("rst_last", o_last, 0);
          #1 rst_n = 1'b1;
          q.delete();
          done = 1;
        end else begin
          chk("subkey", o_sk, q[0].sk);
          chk("sk_round", o_rnd, q[0].r);
          chk("sk_stage", o_stg, q[0].s);
          chk("sk_last", o_last, q[0].last);
          if (ready) begin
            log_sk.push_back(o_sk);
            log_last.push_back(o_last);
            void'(q.pop_front());
          end
        end
      end
    end
    if (mode != 2 && cyc <= 400) begin
      @(negedge clk);
      chk("valid_drop", o_v, 0);
      chk("busy_drop", o_busy, 0);
      chk("key_ready_back", o_kr, 1);
    end
    sk_ready = 1'b0;
  endtask

`ifdef DES_KS_PARITY_CHECK_EN
  task automatic parity_reject(input bit s3, input logic [191:0] k);
    sel3 = s3;
    @(negedge clk);
    key_in = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    chk("perr_pulse", o_err, 1);
    chk("perr_novalid", o_v, 0);
    chk("perr_ready", o_kr, 1);
    @(posedge clk);
    #1;
    chk("perr_clear", o_err, 0);
    chk("perr_novalid2", o_v, 0);
    chk("perr_ready2", o_kr, 1);
  endtask
`endif

  initial begin
    logic [191:0] rk;
    rst_n = 1'b0;
    key_valid = 1'b0;
    sk_ready = 1'b0;
    decrypt = 1'b0;
    sel3 = 1'b0;
    key_in = '0;
    #1;
    chk("rst_valid1", skv1, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_last1", last1, 0);
    chk("rst_err1", err1, 0);
    chk("rst_valid3", skv3, 0);
    chk("rst_busy3", busy3, 0);
    #20 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready1", kr1, 1);
    chk("rst_ready3", kr3, 1);

    run_job(0, {KAT, 128'd0}, 0, 100, 0);
    chk("t1_count", log_sk.size(), 16);
    chk("t1_b0", log_sk[0], 48'h1B02EFFC7072);
    chk("t1_b1", log_sk[1], 48'h79AED9DBC9E5);
    chk("t1_b15", log_sk[15], 48'hCB3D8B0E17F5);
    chk("t1_last15", log_last[15], 1);
    chk("t1_last14", log_last[14], 0);

    run_job(0, {KAT, 128'd0}, 1, 100, 0);
    chk("t2_b0", log_sk[0], 48'hCB3D8B0E17F5);
    chk("t2_b15", log_sk[15], 48'h1B02EFFC7072);

    run_job(0, {KAT, 128'd0}, 0, 100, 1);
    chk("t3_b0", log_sk[0], 48'h1B02EFFC7072);
    chk("t3_b1", log_sk[1], 48'h79AED9DBC9E5);
    chk("t3_b15", log_sk[15], 48'hCB3D8B0E17F5);

    run_job(1, {KAT, KAT, KAT}, 0, 100, 0);
    chk("t4_count", log_sk.size(), 48);
    chk("t4_s0b0", log_sk[0], 48'h1B02EFFC7072);
    chk("t4_s1b0", log_sk[16], 48'hCB3D8B0E17F5);
    chk("t4_s2b0", log_sk[32], 48'h1B02EFFC7072);
    chk("t4_last15", log_last[15], 0);
    chk("t4_last47", log_last[47], 1);

`ifdef DES_KS_PARITY_CHECK_EN
    parity_reject(0, {KBAD, 128'd0});
    parity_reject(1, {KAT, KBAD, KAT});
    run_job(0, {KAT, 128'd0}, 0, 100, 0);
    chk("t5_good_b0", log_sk[0], 48'h1B02EFFC7072);
`else
    run_job(0, {KBAD, 128'd0}, 0, 100, 0);
    chk("t5_nopar_b0", log_sk[0], 48'h1B02EFFC7072);
`endif

    run_job(0, {KAT, 128'd0}, 0, 100, 2);
    run_job(0, {KAT, 128'd0}, 0, 100, 0);
    chk("t6_b0", log_sk[0], 48'h1B02EFFC7072);
    chk("t6_b15", log_sk[15], 48'hCB3D8B0E17F5);
    run_job(1, {KAT, KAT, KAT}, 1, 100, 2);

    for (int j = 0; j < 16; j++) begin
      rk = {fix_par({$urandom, $urandom}),
            fix_par({$urandom, $urandom}),
            fix_par({$urandom, $urandom})};
      run_job(1'($urandom_range(1)), rk, 1'($urandom_range(1)),
              $urandom_range(100, 30), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
